// File: rtl/pcie_rx_pkt_buffer.sv
// Store-and-forward TLP buffer between the PCIe core RX port and the bridge RX input.
// A packet becomes visible to the read side only after its EOF word is written cleanly.
// Discontinued, poisoned, truncated or oversized packets are rolled back to the commit
// pointer and counted, so the bridge never sees a partial TLP.
module pcie_rx_pkt_buffer #(
    parameter int unsigned DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_sof_n,
    input  logic        in_eof_n,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_rem_n,
    input  logic        in_src_rdy_n,
    output logic        in_dst_rdy_n,
    input  logic        in_src_dsc_n,
    input  logic        in_err_fwd_n,
    input  logic [6:0]  in_bar_hit_n,
    output logic        out_sof_n,
    output logic        out_eof_n,
    output logic [63:0] out_data,
    output logic [7:0]  out_rem_n,
    output logic [6:0]  out_bar_hit_n,
    output logic        out_src_rdy_n,
    input  logic        out_dst_rdy_n,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
);

    localparam int unsigned ADDR = $clog2(DEPTH);
    localparam logic [ADDR:0] PTR_ONE  = (ADDR+1)'(1);
    localparam logic [ADDR:0] PTR_FULL = (ADDR+1)'(DEPTH);

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  rem_n;
        logic        sof_n;
        logic        eof_n;
        logic [6:0]  bar_hit_n;
    } entry_t;

    localparam entry_t ENTRY_RESET = {64'd0, 8'hFF, 1'b1, 1'b1, 7'h7F};

    typedef enum logic [1:0] {WIdle, WPkt, WDrop} wr_state_e;

    entry_t            mem [DEPTH];
    wr_state_e         state_q, state_d;
    logic [ADDR:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR:0]     wr_commit_q, wr_commit_d;
    logic [ADDR:0]     commit_rd_q;
    logic [ADDR:0]     rd_ptr_q, rd_ptr_d;
    logic              poison_q, poison_d;
    logic [6:0]        bar_q, bar_d;
    logic              rdy_q;
    entry_t            out_q;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [ADDR:0]     used;
    logic [ADDR:0]     committed;
    logic [ADDR:0]     rd_next;
    logic              oversize;
    logic              in_acc;
    logic              start;
    logic              poison_nxt;
    logic              mem_we;
    logic [ADDR-1:0]   wr_addr;
    entry_t            wr_entry;
    logic [1:0]        drop_inc;
    logic [16:0]       drop_sum;
    logic              out_xfer;
    logic              load;
    logic [ADDR-1:0]   rd_addr;

    // used includes the word parked in the output register; rd_ptr only moves on transfer.
    assign used         = wr_ptr_q - rd_ptr_q;
    assign oversize     = (used == PTR_FULL) && (wr_commit_q == rd_ptr_q);
    assign in_dst_rdy_n = ~rdy_q | ((state_q != WDrop) && (used == PTR_FULL));
    assign in_acc       = ~in_src_rdy_n & ~in_dst_rdy_n;
    assign wr_entry     = {in_data, in_rem_n, in_sof_n, in_eof_n,
                           (start ? in_bar_hit_n : bar_q)};

    // Write FSM: append, commit on clean EOF, roll back to wr_commit on any fault.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        poison_d    = poison_q;
        bar_d       = bar_q;
        drop_inc    = 2'd0;
        mem_we      = 1'b0;
        wr_addr     = wr_ptr_q[ADDR-1:0];
        start       = 1'b0;
        poison_nxt  = poison_q | ~in_err_fwd_n;
        unique case (state_q)
            WIdle: begin
                if (in_acc && !in_sof_n) start = 1'b1;
            end
            WPkt: begin
                if (!in_src_dsc_n) begin
                    wr_ptr_d = wr_commit_q;
                    drop_inc = 2'd1;
                    state_d  = WIdle;
                end else if (oversize) begin
                    wr_ptr_d = wr_commit_q;
                    drop_inc = 2'd1;
                    state_d  = WDrop;
                end else if (in_acc) begin
                    if (!in_sof_n) begin
                        // Missing EOF: drop the open packet, restart at the commit point.
                        drop_inc = 2'd1;
                        start    = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        poison_d = poison_nxt;
                        if (!in_eof_n) begin
                            state_d = WIdle;
                            if (poison_nxt) begin
                                wr_ptr_d = wr_commit_q;
                                drop_inc = 2'd1;
                            end else begin
                                wr_commit_d = wr_ptr_q + PTR_ONE;
                            end
                        end
                    end
                end
            end
            WDrop: begin
                if (!in_src_dsc_n || (in_acc && !in_eof_n)) state_d = WIdle;
            end
            default: state_d = WIdle;
        endcase
        if (start) begin
            mem_we   = 1'b1;
            wr_addr  = wr_commit_q[ADDR-1:0];
            wr_ptr_d = wr_commit_q + PTR_ONE;
            poison_d = ~in_err_fwd_n;
            bar_d    = in_bar_hit_n;
            state_d  = WPkt;
            if (!in_eof_n) begin
                state_d = WIdle;
                if (!in_err_fwd_n) begin
                    wr_ptr_d = wr_commit_q;
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    wr_commit_d = wr_commit_q + PTR_ONE;
                end
            end
        end
        drop_sum   = {1'b0, drop_cnt_q} + {15'd0, drop_inc};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Read side: FWFT output register, refilled in the same cycle as a transfer.
    // committed uses a one-cycle-delayed copy of wr_commit so the RAM write has landed.
    always_comb begin
        committed   = commit_rd_q - rd_ptr_q;
        rd_next     = rd_ptr_q + PTR_ONE;
        out_xfer    = out_valid_q & ~out_dst_rdy_n;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        rd_addr     = rd_ptr_q[ADDR-1:0];
        pkt_cnt_d   = pkt_cnt_q;
        if (out_xfer) begin
            rd_ptr_d    = rd_next;
            rd_addr     = rd_next[ADDR-1:0];
            load        = (committed > PTR_ONE);
            out_valid_d = load;
            if (!out_q.eof_n) pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else if (!out_valid_q && (committed != '0)) begin
            load        = 1'b1;
            out_valid_d = 1'b1;
        end
    end

    // Packet RAM; no reset, only words behind the commit pointer are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_addr] <= wr_entry;
    end

    // State, pointers, counters and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WIdle;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            commit_rd_q <= '0;
            rd_ptr_q    <= '0;
            poison_q    <= 1'b0;
            bar_q       <= 7'h7F;
            rdy_q       <= 1'b0;
            out_q       <= ENTRY_RESET;
            out_valid_q <= 1'b0;
            pkt_cnt_q   <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            commit_rd_q <= wr_commit_q;
            rd_ptr_q    <= rd_ptr_d;
            poison_q    <= poison_d;
            bar_q       <= bar_d;
            rdy_q       <= 1'b1;
            if (load) out_q <= mem[rd_addr];
            out_valid_q <= out_valid_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_src_rdy_n = ~out_valid_q;
    assign out_sof_n     = out_q.sof_n;
    assign out_eof_n     = out_q.eof_n;
    assign out_data      = out_q.data;
    assign out_rem_n     = out_q.rem_n;
    assign out_bar_hit_n = out_q.bar_hit_n;
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pcie_rx_pkt_buffer.sv
// Bench for pcie_rx_pkt_buffer: directed steps plus random packets, checked against a
// packet-level model (queue of expected output words, expected counters).
module tb_pcie_rx_pkt_buffer;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_sof_n, in_eof_n, in_src_rdy_n, in_src_dsc_n, in_err_fwd_n;
    logic [63:0] in_data;
    logic [7:0]  in_rem_n;
    logic [6:0]  in_bar_hit_n;
    logic        in_dst_rdy_n;
    logic        out_sof_n, out_eof_n, out_src_rdy_n, out_dst_rdy_n;
    logic [63:0] out_data;
    logic [7:0]  out_rem_n;
    logic [6:0]  out_bar_hit_n;
    logic [15:0] pkt_cnt, drop_cnt;

    pcie_rx_pkt_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_sof_n(in_sof_n), .in_eof_n(in_eof_n), .in_data(in_data), .in_rem_n(in_rem_n),
        .in_src_rdy_n(in_src_rdy_n), .in_dst_rdy_n(in_dst_rdy_n),
        .in_src_dsc_n(in_src_dsc_n), .in_err_fwd_n(in_err_fwd_n),
        .in_bar_hit_n(in_bar_hit_n),
        .out_sof_n(out_sof_n), .out_eof_n(out_eof_n), .out_data(out_data),
        .out_rem_n(out_rem_n), .out_bar_hit_n(out_bar_hit_n),
        .out_src_rdy_n(out_src_rdy_n), .out_dst_rdy_n(out_dst_rdy_n),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  rem_n;
        logic        sof_n;
        logic        eof_n;
        logic [6:0]  bar_n;
    } word_t;

    word_t exp_q[$];
    word_t mw;
    int    total = 0;
    int    bad = 0;
    int    out_mode = 0;   // 0: always ready, 1: stalled, 2: random
    int    exp_pkt = 0;
    int    exp_drop = 0;
    int    exp_wptr = 0;   // committed words since reset
    int    r_len, r_kind, r_mark, r_k;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && !out_src_rdy_n && !out_dst_rdy_n) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {63'd0, out_src_rdy_n}, 64'd1);
            end else begin
                mw = exp_q.pop_front();
                check("out_data", out_data, mw.data);
                check("out_sof", {63'd0, out_sof_n}, {63'd0, mw.sof_n});
                check("out_eof", {63'd0, out_eof_n}, {63'd0, mw.eof_n});
                check("out_bar", {57'd0, out_bar_hit_n}, {57'd0, mw.bar_n});
                if (!mw.eof_n) check("out_rem", {56'd0, out_rem_n}, {56'd0, mw.rem_n});
            end
        end
    end

    // Output-side ready driver.
    initial begin
        out_dst_rdy_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0:       out_dst_rdy_n = 1'b0;
                1:       out_dst_rdy_n = 1'b1;
                default: out_dst_rdy_n = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        in_src_rdy_n = 1'b1; in_sof_n = 1'b1; in_eof_n = 1'b1; in_src_dsc_n = 1'b1;
        in_err_fwd_n = 1'b1; in_data = '0; in_rem_n = 8'hFF; in_bar_hit_n = 7'h7F;
    endtask

    task automatic drive(input word_t w, input logic dsc_n, input logic err_n);
        in_src_rdy_n = 1'b0; in_sof_n = w.sof_n; in_eof_n = w.eof_n; in_data = w.data;
        in_rem_n = w.rem_n; in_bar_hit_n = w.bar_n; in_src_dsc_n = dsc_n; in_err_fwd_n = err_n;
    endtask

    // Offer one word, return #1 after the edge that accepts it.
    task automatic send_word(input word_t w, input logic dsc_n, input logic err_n);
        int n = 0;
        drive(w, dsc_n, err_n);
        forever begin
            @(negedge clk);
            if (!in_dst_rdy_n) break;
            n++;
            if (n > 500) begin
                check("accept_timeout", {63'd0, in_dst_rdy_n}, 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // kind: 0 clean, 1 discontinue on word mark, 2 poison on word mark,
    //       3 oversize (expected drop), 4 truncated (EOF never sent).
    task automatic send_pkt(input int len, input int kind, input int mark,
                            input logic [6:0] bar, input int hold_at, input int gap_max);
        word_t w;
        word_t pkt[$];
        int n_send = len;
        if (kind == 4) n_send = len - 1;
        if (kind == 1) n_send = mark + 1;
        for (int i = 0; i < n_send; i++) begin
            w.data  = {$urandom, $urandom};
            w.rem_n = 8'($urandom);
            w.sof_n = (i != 0);
            w.eof_n = (i != len - 1);
            w.bar_n = (i == 0) ? bar : 7'($urandom);
            if (i == hold_at) begin
                drive(w, 1'b1, 1'b1);
                repeat (4) begin
                    @(negedge clk);
                    check("full_backpressure", {63'd0, in_dst_rdy_n}, 64'd1);
                end
                out_mode = 0;
            end
            send_word(w, !(kind == 1 && i == mark), !(kind == 2 && i == mark));
            w.bar_n = bar;
            pkt.push_back(w);
            if (i < n_send - 1 && gap_max > 0) gap($urandom_range(0, gap_max));
        end
        if (kind == 0) begin
            foreach (pkt[j]) exp_q.push_back(pkt[j]);
            exp_pkt++;
            exp_wptr += len;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic drain_and_check(input string tag);
        int n = 0;
        out_mode = 0;
        while ((exp_q.size() != 0 || !out_src_rdy_n) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        gap(3);
        check({tag, "_drained"}, exp_q.size(), 64'd0);
        check({tag, "_pkt_cnt"}, {48'd0, pkt_cnt}, 64'(exp_pkt));
        check({tag, "_drop_cnt"}, {48'd0, drop_cnt}, 64'(exp_drop));
        check({tag, "_wr_ptr"}, {59'd0, dut.wr_ptr_q}, 64'(exp_wptr % (2 * DEPTH)));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_rdy"}, {63'd0, in_dst_rdy_n}, 64'd1);
        check({tag, "_out_rdy"}, {63'd0, out_src_rdy_n}, 64'd1);
        check({tag, "_sof_eof"}, {62'd0, out_sof_n, out_eof_n}, 64'd3);
        check({tag, "_data"}, out_data, 64'd0);
        check({tag, "_rem_bar"}, {49'd0, out_rem_n, out_bar_hit_n}, {49'd0, 8'hFF, 7'h7F});
        check({tag, "_cnts"}, {32'd0, pkt_cnt, drop_cnt}, 64'd0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_still_busy", {63'd0, in_dst_rdy_n}, 64'd1);
        @(posedge clk); #1;
        check("rst_release_ready", {63'd0, in_dst_rdy_n}, 64'd0);
    endtask

    initial begin
        word_t stray;
        idle_inputs();
        // Reset values
        gap(3);
        check_reset_values("reset");
        release_reset();

        // Single 4-word TLP, BAR 0x7E: first word appears two edges after the EOF edge
        out_mode = 0;
        send_pkt(4, 0, 0, 7'h7E, -1, 0);
        check("lat_t0", {63'd0, out_src_rdy_n}, 64'd1);
        @(posedge clk); #1;
        check("lat_t1", {63'd0, out_src_rdy_n}, 64'd1);
        @(posedge clk); #1;
        check("lat_t2_valid", {63'd0, out_src_rdy_n}, 64'd0);
        check("lat_t2_sof", {63'd0, out_sof_n}, 64'd0);
        check("lat_t2_bar", {57'd0, out_bar_hit_n}, 64'h7E);
        drain_and_check("single");

        // Discontinue on word 2 of a 3-word TLP, then a clean 2-word TLP
        send_pkt(3, 1, 1, 7'h3D, -1, 1);
        send_pkt(2, 0, 0, 7'h5B, -1, 1);
        drain_and_check("dsc");

        // Poisoned EOF word: dropped, write pointer back where it was
        send_pkt(3, 2, 2, 7'h11, -1, 0);
        gap(2);
        check("poison_wr_ptr", {59'd0, dut.wr_ptr_q}, 64'(exp_wptr % (2 * DEPTH)));
        drain_and_check("poison");

        // Non-SOF word while idle is silently discarded
        stray = '{data: 64'hDEAD_BEEF_0000_0001, rem_n: 8'h00, sof_n: 1'b1, eof_n: 1'b0,
                  bar_n: 7'h01};
        send_word(stray, 1'b1, 1'b1);
        drain_and_check("stray");

        // Output stalled: three 6-word TLPs, back-pressure after 16 words, then release
        out_mode = 1;
        gap(2);
        send_pkt(6, 0, 0, 7'h21, -1, 0);
        send_pkt(6, 0, 0, 7'h22, -1, 0);
        send_pkt(6, 0, 0, 7'h23, 4, 0);
        drain_and_check("flood");

        // Oversized 20-word TLP dropped, following 2-word TLP forwarded
        send_pkt(20, 3, 0, 7'h40, -1, 0);
        send_pkt(2, 0, 0, 7'h41, -1, 0);
        drain_and_check("oversize");

        // Truncated packet (missing EOF) followed by a clean one
        send_pkt(4, 4, 0, 7'h50, -1, 0);
        send_pkt(3, 0, 0, 7'h51, -1, 0);
        drain_and_check("trunc");

        // Random packet mix with random output back-pressure
        for (int p = 0; p < 30; p++) begin
            r_k    = $urandom_range(0, 9);
            r_len  = $urandom_range(1, 8);
            out_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            if (r_k < 5 || r_len < 2) r_kind = 0;
            else if (r_k < 7)         r_kind = 1;
            else if (r_k < 9)         r_kind = 2;
            else                      r_kind = 4;
            r_mark = (r_kind == 0) ? 0 : $urandom_range(1, r_len - 1);
            send_pkt(r_len, r_kind, r_mark, 7'($urandom), -1, 2);
            if (r_kind == 4) begin
                r_len = $urandom_range(1, 8);
                send_pkt(r_len, 0, 0, 7'($urandom), -1, 2);
            end
        end
        drain_and_check("random");

        // Reset while a packet sits in the stalled output register
        out_mode = 1;
        gap(2);
        send_pkt(3, 0, 0, 7'h33, -1, 0);
        gap(4);
        check("pre_reset_valid", {63'd0, out_src_rdy_n}, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_pkt = 0; exp_drop = 0; exp_wptr = 0;
        check_reset_values("midrst");
        gap(2);
        out_mode = 0;
        release_reset();
        send_pkt(5, 0, 0, 7'h0F, -1, 1);
        drain_and_check("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
